// File: rtl/instruction_fetch.sv
// Instruction fetch: drives the memory address, waits MEM_LATENCY cycles, captures the word
// and offers it to decode over valid/ready. Bounds checking is compiled in by FETCH_BOUNDS_CHECK_EN.
module instruction_fetch #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] address,
    input  logic [31:0] instruction,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        fetch_fault
);

    localparam int unsigned CW = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LATENCY - 1);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [32:0] ADDR_LIMIT = 33'(IMEM_WORDS) << 2;
    typedef enum logic [1:0] {S_WAIT = 2'd0, S_VALID = 2'd1, S_FAULT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_WAIT = 2'd0, S_VALID = 2'd1} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pc_q, pc_d;
    logic          issue;
    logic [31:0]   issue_addr;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        issue      = 1'b0;
        issue_addr = addr_q + 32'd4;

        case (state_q)
            S_WAIT: begin
                if (redirect) begin
                    issue      = 1'b1;
                    issue_addr = redirect_target & 32'hFFFF_FFFC;
                end else if (count_q == LAST) begin
                    instr_d = instruction;
                    pc_d    = addr_q;
                    count_d = '0;
                    state_d = S_VALID;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_VALID: begin
                // A redirect coinciding with a handshake still lets decode take the word.
                if (redirect) begin
                    issue      = 1'b1;
                    issue_addr = redirect_target & 32'hFFFF_FFFC;
                end else if (instr_ready) begin
                    issue = 1'b1;
                end
            end
`ifdef FETCH_BOUNDS_CHECK_EN
            S_FAULT: ;
`endif
            default: state_d = S_WAIT;
        endcase

        if (issue) begin
            addr_d  = issue_addr;
            count_d = '0;
            state_d = S_WAIT;
`ifdef FETCH_BOUNDS_CHECK_EN
            if ({1'b0, issue_addr} >= ADDR_LIMIT) state_d = S_FAULT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_WAIT;
            count_q <= '0;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign address     = addr_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign instr_valid = (state_q == S_VALID);
`ifdef FETCH_BOUNDS_CHECK_EN
    assign fetch_fault = (state_q == S_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a transaction-timing reference model.
module tb_instruction_fetch;

    localparam int unsigned ML  = 2;
    localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef FETCH_BOUNDS_CHECK_EN
    localparam int unsigned WORDS = 4;
`else
    localparam int unsigned WORDS = 1024;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] instruction;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instruction_fetch #(
        .MEM_LATENCY(ML),
        .RESET_PC   (RPC),
        .IMEM_WORDS (WORDS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .instruction    (instruction),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .fetch_fault    (fetch_fault)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Odd multiplier makes every word address map to a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: next fetch address, presented word, elapsed wait cycles.
    logic [31:0] m_addr = '0, m_pc = '0, m_instr = '0;
    logic        m_valid = 1'b0, m_fault = 1'b0;
    int          m_age = 0;

    // Memory side: data is only meaningful once the address has been stable ML-1 cycles.
    logic [31:0] seen_addr = '0;
    int          seen_age  = 0;

    task automatic model_step(input logic r, input logic rdy, input logic rd, input logic [31:0] tgt);
        if (r) begin
            m_addr = RPC; m_valid = 1'b0; m_pc = '0; m_instr = '0; m_fault = 1'b0; m_age = 0;
        end else if (!m_fault) begin
            if (rd || (m_valid && rdy)) begin
                m_addr  = rd ? (tgt & 32'hFFFF_FFFC) : m_addr + 32'd4;
                m_valid = 1'b0;
                m_age   = 0;
`ifdef FETCH_BOUNDS_CHECK_EN
                if ({1'b0, m_addr} >= 33'(WORDS) * 33'd4) m_fault = 1'b1;
`endif
            end else if (!m_valid) begin
                m_age++;
                if (m_age == ML) begin
                    m_valid = 1'b1;
                    m_pc    = m_addr;
                    m_instr = mem_word(m_addr);
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after checking outputs.
    task automatic cycle(input logic r, input logic rdy, input logic rd, input logic [31:0] tgt);
        if (address !== seen_addr) begin
            seen_addr = address;
            seen_age  = 0;
        end else begin
            seen_age++;
        end
        instruction     = (seen_age >= ML - 1) ? mem_word(address) : $urandom();
        reset           = r;
        instr_ready     = rdy;
        redirect        = rd;
        redirect_target = tgt;
        @(posedge clk);
        model_step(r, rdy, rd, tgt);
        @(negedge clk);
        check_eq("address", address, m_addr);
        check_eq("instr_valid", instr_valid, m_valid);
        check_eq("pc_out", pc_out, m_pc);
        check_eq("instr_out", instr_out, m_instr);
        check_eq("fetch_fault", fetch_fault, m_fault);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (m_valid) break;
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0;
        redirect_target = '0; instruction = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("rst_addr", address, RPC);
        check_eq("rst_valid", instr_valid, 1'b0);

`ifdef FETCH_BOUNDS_CHECK_EN
        repeat (12) cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("fault_addr", address, 32'd16);
        check_eq("fault_flag", fetch_fault, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0);
        check_eq("fault_redir_ignored", address, 32'd16);
        check_eq("fault_no_valid", instr_valid, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("fault_cleared", fetch_fault, 1'b0);
`else
        // Sequential stream with ready held high
        repeat (12) cycle(1'b0, 1'b1, 1'b0, 32'h0);

        // Stall after first valid
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        wait_valid();
        check_eq("stall_pc", pc_out, 32'h0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("stall_addr", address, 32'h0);
        check_eq("stall_instr", instr_out, mem_word(32'h0));
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("step_addr", address, 32'h4);

        // Redirect during WAIT discards the in-flight word
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0013);
        check_eq("redir_addr", address, 32'h10);
        wait_valid();
        check_eq("redir_pc", pc_out, 32'h10);

        // Redirect coinciding with handshake at pc 8
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 30; i++) begin
            if (m_valid && m_pc == 32'h8) break;
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
        end
        check_eq("hs_pc8", pc_out, 32'h8);
        cycle(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        check_eq("hs_redir_addr", address, 32'h200);
        wait_valid();
        check_eq("hs_redir_pc", pc_out, 32'h200);

        // Reset while a word is presented
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("rst_mid_valid", instr_valid, 1'b0);
        check_eq("rst_mid_addr", address, RPC);
        wait_valid();
        check_eq("restart_pc", pc_out, RPC);

        // Address wrap at top of the address space
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        wait_valid();
        check_eq("wrap_pc", pc_out, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("wrap_addr", address, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, rdy, rd;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 49) == 0);
            rdy = $urandom_range(0, 1) == 1;
            rd  = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 8191));
            cycle(r, rdy, rd, tgt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
